// File: rtl/contador_bcd_pkg.sv
// Shared types, constants and helpers for the four-decade BCD counter.
package contador_bcd_pkg;

   typedef logic [3:0] digito_bcd_t;

   localparam digito_bcd_t BCD_MAX = 4'd9;

   // Map any non-decimal nibble (A..F) to zero so a bad load can never
   // push a digit outside 0..9.
   function automatic digito_bcd_t sanear_bcd(input logic [3:0] nibble);
      return (nibble > BCD_MAX) ? digito_bcd_t'(4'd0) : digito_bcd_t'(nibble);
   endfunction

endpackage

// File: rtl/contador_bcd_9999_digito.sv
// One BCD decade: holds a digit 0..9, steps up or down when paso is set,
// and flags a carry/borrow for the next decade in the chain.
module digito_bcd
   import contador_bcd_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cargar,
   input  digito_bcd_t valor,
   input  logic        paso,
   input  logic        abajo,
   output digito_bcd_t digito,
   output logic        acarreo
);

   digito_bcd_t digito_reg;
   digito_bcd_t digito_next;

   // Next digit on a step: wrap 9->0 counting up, 0->9 counting down.
   always_comb begin
      digito_next = digito_reg;
      if (abajo) begin
         if (digito_reg == 4'd0) begin
            digito_next = BCD_MAX;
         end else begin
            digito_next = digito_reg - 4'd1;
         end
      end else begin
         if (digito_reg >= BCD_MAX) begin
            digito_next = 4'd0;
         end else begin
            digito_next = digito_reg + 4'd1;
         end
      end
   end

   // Digit register: reset beats load, load beats step.
   always_ff @(posedge clk) begin
      if (rst) begin
         digito_reg <= 4'd0;
      end else if (cargar) begin
         digito_reg <= valor;
      end else if (paso) begin
         digito_reg <= digito_next;
      end
   end

   // Carry (up) or borrow (down) ripples to the next decade in the same cycle.
   assign acarreo = paso && (abajo ? (digito_reg == 4'd0) : (digito_reg == BCD_MAX));
   assign digito  = digito_reg;

endmodule

// File: rtl/contador_bcd_9999.sv
// Four-decade synchronous BCD counter 0000..9999 driven by a prescaler tick.
// Optional down counting is compiled in with the macro CUENTA_ABAJO_EN;
// without it the direccion input is ignored and the counter only counts up.
module contador_bcd_9999
   import contador_bcd_pkg::*;
#(
   parameter int unsigned DIV = 50_000_000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        habilitar,
   input  logic        cargar,
   input  logic [15:0] valor_carga,
   input  logic        direccion,
   output logic [3:0]  bcd_unidades,
   output logic [3:0]  bcd_decenas,
   output logic [3:0]  bcd_centenas,
   output logic [3:0]  bcd_millares,
   output logic        tick_cuenta,
   output logic        fin_cuenta
);

   localparam logic [31:0] PRE_MAX = 32'(DIV - 1);

   logic [31:0] pre_reg;
   logic        paso_cuenta;
   logic        abajo;
   logic        tick_reg;
   logic        fin_reg;

   digito_bcd_t digitos [4];
   logic [4:0]  paso_cadena;
   logic [3:0]  acarreos;

`ifdef CUENTA_ABAJO_EN
   assign abajo = direccion;
`else
   logic unused_direccion;
   assign unused_direccion = direccion;
   assign abajo = 1'b0;
`endif

   // Prescaler: counts enabled cycles 0..DIV-1; a load or reset restarts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_reg <= 32'd0;
      end else if (cargar) begin
         pre_reg <= 32'd0;
      end else if (habilitar) begin
         if (pre_reg == PRE_MAX) begin
            pre_reg <= 32'd0;
         end else begin
            pre_reg <= pre_reg + 32'd1;
         end
      end
   end

   assign paso_cuenta    = habilitar && (pre_reg == PRE_MAX);
   assign paso_cadena[0] = paso_cuenta;

   // Decade chain: each digit steps when every lower digit carries/borrows.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digito
         digito_bcd u_digito (
            .clk     (clk),
            .rst     (rst),
            .cargar  (cargar),
            .valor   (sanear_bcd(valor_carga[gi*4 +: 4])),
            .paso    (paso_cadena[gi]),
            .abajo   (abajo),
            .digito  (digitos[gi]),
            .acarreo (acarreos[gi])
         );
         assign paso_cadena[gi+1] = acarreos[gi];
      end
   endgenerate

   // Output pulses follow the step by one cycle; a load suppresses them.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_reg <= 1'b0;
         fin_reg  <= 1'b0;
      end else begin
         tick_reg <= paso_cuenta && !cargar;
         fin_reg  <= paso_cadena[4] && !cargar;
      end
   end

   assign bcd_unidades = digitos[0];
   assign bcd_decenas  = digitos[1];
   assign bcd_centenas = digitos[2];
   assign bcd_millares = digitos[3];
   assign tick_cuenta  = tick_reg;
   assign fin_cuenta   = fin_reg;

endmodule
